// File: rtl/ddr_rd_pkg.sv
// Shared constants, state encoding and offset helper for the DDR burst reader.
package ddr_rd_pkg;

  localparam logic [2:0]  AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned BEAT_BYTES     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rd_state_e;

  // Advance the frame offset by one burst, wrapping to zero at the frame end.
  function automatic logic [31:0] next_offset(input logic [31:0] off,
                                              input logic [31:0] burst_bytes,
                                              input logic [31:0] frame_bytes);
    logic [31:0] sum;
    sum = off + burst_bytes;
    if (sum >= frame_bytes) return 32'd0;
    return sum;
  endfunction

endpackage

// File: rtl/ddr_burst_rd_sync_pulse.sv
// Two-flop synchronizer plus registered rising-edge detector.
// A rise on d_i produces a single-cycle pulse_o three clocks later.
module sync_pulse (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  // Synchronize the level and flag its rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/ddr_burst_rd.sv
// AXI4 read master: one INCR burst per rd_start edge, streamed into the pixel
// cache FIFO. Walks the frame buffer linearly and wraps at FRAME_BYTES.
// Handshakes: an AXI transfer happens on a rising edge where valid and ready
// are both high; valid never depends on ready and the payload (araddr) is held
// stable for as long as arvalid is high.
module ddr_burst_rd
  import ddr_rd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'd3145728,
  parameter logic [8:0]  BURST_LEN   = 9'd64
) (
  input  logic         sclk,
  input  logic         rst_n,
  input  logic         rd_start,
  input  logic         frame_sync,
  output logic [31:0]  m_axi_araddr,
  output logic [7:0]   m_axi_arlen,
  output logic [2:0]   m_axi_arsize,
  output logic [1:0]   m_axi_arburst,
  output logic         m_axi_arvalid,
  input  logic         m_axi_arready,
  input  logic [127:0] m_axi_rdata,
  input  logic [1:0]   m_axi_rresp,
  input  logic         m_axi_rlast,
  input  logic         m_axi_rvalid,
  output logic         m_axi_rready,
  output logic [127:0] rd_128bit_data,
  output logic         cache_wr_en,
  output logic         rd_end,
  output logic         busy,
  output logic         rd_err,
  output logic [1:0]   dbg_state_o,
  output logic [8:0]   dbg_beat_cnt_o
);

  localparam logic [31:0] BURST_BYTES = {23'd0, BURST_LEN} * 32'(BEAT_BYTES);

  rd_state_e      state_q, state_d;
  logic [31:0]    araddr_q, araddr_d;
  logic           arvalid_q, arvalid_d;
  logic [31:0]    offset_q, offset_d;
  logic           pending_q, pending_d;
  logic           resync_q, resync_d;
  logic [8:0]     beat_cnt_q, beat_cnt_d;
  logic           wr_en_q;
  logic [127:0]   data_q;
  logic           end_q;
  logic           err_q;
  logic           req;
  logic           rready;
  logic           beat_acc;

  sync_pulse u_sync (
    .clk_i  (sclk),
    .rst_ni (rst_n),
    .d_i    (rd_start),
    .pulse_o(req)
  );

  assign rready   = (state_q == DATA);
  assign beat_acc = m_axi_rvalid & rready;

  // Next-state logic: request queueing, address issue, beat counting, offset walk.
  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    offset_d   = offset_q;
    pending_d  = pending_q;
    resync_d   = resync_q | frame_sync;
    beat_cnt_d = beat_cnt_q;

    // A request arriving mid-burst is remembered once; further ones are lost.
    if (req && (state_q != IDLE)) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_sync || resync_q) begin
          offset_d = 32'd0;
          resync_d = 1'b0;
        end
        if (req || pending_q) begin
          state_d    = ADDR;
          arvalid_d  = 1'b1;
          araddr_d   = BASE_ADDR + ((frame_sync || resync_q) ? 32'd0 : offset_q);
          pending_d  = 1'b0;
          beat_cnt_d = 9'd0;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (beat_acc) begin
          if (beat_cnt_q != BURST_LEN) beat_cnt_d = beat_cnt_q + 9'd1;
          if (m_axi_rlast) state_d = DONE;
        end
      end
      DONE: begin
        offset_d = resync_d ? 32'd0 : next_offset(offset_q, BURST_BYTES, FRAME_BYTES);
        resync_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      araddr_q   <= BASE_ADDR;
      arvalid_q  <= 1'b0;
      offset_q   <= 32'd0;
      pending_q  <= 1'b0;
      resync_q   <= 1'b0;
      beat_cnt_q <= 9'd0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      offset_q   <= offset_d;
      pending_q  <= pending_d;
      resync_q   <= resync_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Registered cache write path; rd_end lines up with the final write strobe.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      data_q  <= '0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_en_q <= beat_acc;
      if (beat_acc) data_q <= m_axi_rdata;
      end_q   <= beat_acc & m_axi_rlast;
      if (beat_acc && (m_axi_rresp != AXI_RESP_OKAY)) err_q <= 1'b1;
    end
  end

  assign m_axi_araddr   = araddr_q;
  assign m_axi_arlen    = 8'(BURST_LEN - 9'd1);
  assign m_axi_arsize   = AXI_SIZE_16B;
  assign m_axi_arburst  = AXI_BURST_INCR;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = rready;
  assign rd_128bit_data = data_q;
  assign cache_wr_en    = wr_en_q;
  assign rd_end         = end_q;
  assign busy           = (state_q != IDLE);
  assign rd_err         = err_q;
  assign dbg_state_o    = state_q;
  assign dbg_beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_ddr_burst_rd.sv
// Self-checking bench for ddr_burst_rd: AXI slave model, address/data
// scoreboards and a frame-offset reference model.
module tb_ddr_burst_rd;
  import ddr_rd_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] FRAME = 32'd3145728;
  localparam int unsigned BB    = 64 * 16;

  // ---------------- clock / reset ----------------
  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  logic         rd_start = 1'b0;
  logic         frame_sync = 1'b0;
  logic [31:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid;
  logic         m_axi_arready;
  logic [127:0] m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast;
  logic         m_axi_rvalid;
  logic         m_axi_rready;
  logic [127:0] rd_128bit_data;
  logic         cache_wr_en;
  logic         rd_end;
  logic         busy;
  logic         rd_err;
  logic [1:0]   dbg_state;
  logic [8:0]   dbg_beat_cnt;

  ddr_burst_rd #(
    .BASE_ADDR  (BASE),
    .FRAME_BYTES(FRAME),
    .BURST_LEN  (9'd64)
  ) dut (
    .sclk          (sclk),
    .rst_n         (rst_n),
    .rd_start      (rd_start),
    .frame_sync    (frame_sync),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .rd_128bit_data(rd_128bit_data),
    .cache_wr_en   (cache_wr_en),
    .rd_end        (rd_end),
    .busy          (busy),
    .rd_err        (rd_err),
    .dbg_state_o   (dbg_state),
    .dbg_beat_cnt_o(dbg_beat_cnt)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [127:0] exp_q[$];
  logic         exp_last_q[$];
  logic [31:0]  exp_addr_q[$];
  int unsigned  m_off = 0;

  // Queue the address the next burst should use and advance the frame walk.
  task automatic push_addr();
    exp_addr_q.push_back(BASE + m_off);
    m_off = (m_off + BB) % FRAME;
  endtask

  // ---------------- AXI slave driver ----------------
  int cfg_ar_delay = 0;
  int cfg_gap      = 0;
  int cfg_nbeats   = 64;
  int cfg_err_beat = -1;
  int cur_beat     = -1;

  initial begin : axi_slave
    int idle;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    forever begin
      step();
      if (rst_n && m_axi_arvalid) begin
        for (int d = 0; d < cfg_ar_delay && rst_n; d++) step();
        m_axi_arready = 1'b1;
        step();
        m_axi_arready = 1'b0;
        for (int b = 0; b < cfg_nbeats && rst_n; b++) begin
          idle = (cfg_gap == 1) ? 1 : ((cfg_gap == 2) ? int'($urandom_range(0, 2)) : 0);
          repeat (idle) step();
          if (!rst_n) break;
          m_axi_rdata  = {$urandom, $urandom, $urandom, $urandom};
          m_axi_rresp  = (b == cfg_err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (b == cfg_nbeats - 1);
          m_axi_rvalid = 1'b1;
          cur_beat     = b;
          exp_q.push_back(m_axi_rdata);
          exp_last_q.push_back(m_axi_rlast);
          step();
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
          m_axi_rresp  = 2'b00;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          wr_cnt = 0;
  int          end_cnt = 0;
  int          ar_cnt = 0;
  bit          ar_active = 0;
  bit          ar_unstable = 0;
  logic [31:0] ar_first = '0;
  logic [31:0] last_ar_addr = '0;
  int          ar_rise_cyc[$];
  int          end_cyc[$];

  always @(negedge sclk) begin
    cyc++;
    if (rst_n) begin
      if (cache_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) fail_now("beat_unexpected", wr_cnt, 0);
        else begin
          check("beat_data", rd_128bit_data, exp_q.pop_front());
          check("rd_end_on_last", {127'd0, rd_end}, {127'd0, exp_last_q.pop_front()});
        end
      end else if (rd_end) fail_now("rd_end_without_wr", 1, 0);
      if (rd_end) begin
        end_cnt++;
        end_cyc.push_back(cyc);
      end
      if (m_axi_arvalid) begin
        if (!ar_active) begin
          ar_active   = 1;
          ar_first    = m_axi_araddr;
          ar_unstable = 0;
          ar_rise_cyc.push_back(cyc);
        end else if (m_axi_araddr !== ar_first) ar_unstable = 1;
        if (m_axi_arready) begin
          ar_cnt++;
          last_ar_addr = m_axi_araddr;
          ar_active    = 0;
          check("araddr_stable", {127'd0, ar_unstable}, 128'd0);
          if (exp_addr_q.size() == 0) fail_now("ar_unexpected", ar_cnt, 0);
          else check("araddr", m_axi_araddr, exp_addr_q.pop_front());
          check("arlen", m_axi_arlen, 8'd63);
          check("arsize", m_axi_arsize, 3'b100);
          check("arburst", m_axi_arburst, 2'b01);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    rd_start = 1'b1;
    step();
    step();
    rd_start = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
  endtask

  task automatic wait_ends(input int target, input string name);
    int n = 0;
    while (end_cnt < target && n < 5000) begin
      step();
      n++;
    end
    if (end_cnt < target) fail_now({name, "_timeout"}, end_cnt, target);
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    rd_start   = 1'b0;
    frame_sync = 1'b0;
    repeat (3) step();
    exp_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    ar_active = 0;
    m_off     = 0;
    rst_n     = 1'b1;
    step();
  endtask

  task automatic do_burst(input int dly, input int gap, input int nb, input string name,
                          input bit chk);
    cfg_ar_delay = dly;
    cfg_gap      = gap;
    cfg_nbeats   = nb;
    wr_cnt       = 0;
    end_cnt      = 0;
    push_addr();
    pulse_start();
    wait_ends(1, name);
    if (chk) begin
      check({name, "_wr_count"}, wr_cnt, nb);
      check({name, "_end_count"}, end_cnt, 1);
      check({name, "_busy"}, {127'd0, busy}, 128'd0);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_araddr"}, m_axi_araddr, BASE);
    check({name, "_arvalid"}, {127'd0, m_axi_arvalid}, 128'd0);
    check({name, "_rready"}, {127'd0, m_axi_rready}, 128'd0);
    check({name, "_wr_en"}, {127'd0, cache_wr_en}, 128'd0);
    check({name, "_data"}, rd_128bit_data, 128'd0);
    check({name, "_rd_end"}, {127'd0, rd_end}, 128'd0);
    check({name, "_busy"}, {127'd0, busy}, 128'd0);
    check({name, "_rd_err"}, {127'd0, rd_err}, 128'd0);
    check({name, "_state"}, dbg_state, 2'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          ar_dly;
    int          gap;
    int          nbeats;
    int          exp_wr;
    int          exp_cnt;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin : main
    int n;

    vecs[0] = '{0, 0, 64, 64, 64, 32'h0000_0000};
    vecs[1] = '{5, 1, 64, 64, 64, 32'h0000_0400};
    vecs[2] = '{2, 2, 64, 64, 64, 32'h0000_0800};
    vecs[3] = '{0, 0, 10, 10, 10, 32'h0000_0C00};
    vecs[4] = '{1, 0, 70, 70, 64, 32'h0000_1000};
    vecs[5] = '{3, 1, 1,  1,  1,  32'h0000_1400};

    #1;
    check_reset_outputs("in_reset");
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check_reset_outputs("after_reset");

    // Table: distinct timing patterns, early and late rlast.
    for (int i = 0; i < 6; i++) begin
      do_burst(vecs[i].ar_dly, vecs[i].gap, vecs[i].nbeats, $sformatf("vec%0d", i), 1'b0);
      check($sformatf("vec%0d_wr_count", i), wr_cnt, vecs[i].exp_wr);
      check($sformatf("vec%0d_end_count", i), end_cnt, 1);
      check($sformatf("vec%0d_addr", i), last_ar_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_beat_cnt", i), dbg_beat_cnt, vecs[i].exp_cnt);
      check($sformatf("vec%0d_idle", i), {127'd0, busy}, 128'd0);
      check($sformatf("vec%0d_rd_err", i), {127'd0, rd_err}, 128'd0);
    end

    // Three request edges during one burst: exactly two bursts, back to back.
    cfg_ar_delay = 5;
    cfg_gap      = 1;
    cfg_nbeats   = 64;
    wr_cnt  = 0;
    end_cnt = 0;
    ar_cnt  = 0;
    ar_rise_cyc.delete();
    end_cyc.delete();
    push_addr();
    push_addr();
    pulse_start();
    n = 0;
    while (!busy && n < 20) begin
      step();
      n++;
    end
    pulse_start();
    pulse_start();
    wait_ends(2, "b2b");
    repeat (30) step();
    check("b2b_ar_count", ar_cnt, 2);
    check("b2b_end_count", end_cnt, 2);
    check("b2b_wr_count", wr_cnt, 128);
    if (ar_rise_cyc.size() >= 2 && end_cyc.size() >= 1)
      check("b2b_restart_gap", ar_rise_cyc[1] - end_cyc[0], 2);
    else fail_now("b2b_restart_gap_missing", ar_rise_cyc.size(), 2);

    // frame_sync in the middle of the burst at offset 0x800.
    apply_reset();
    do_burst(0, 0, 64, "fs_a", 1'b1);
    do_burst(0, 0, 64, "fs_b", 1'b1);
    cfg_gap = 1;
    wr_cnt  = 0;
    end_cnt = 0;
    push_addr();
    pulse_start();
    n = 0;
    while (wr_cnt < 20 && n < 500) begin
      step();
      n++;
    end
    pulse_sync();
    m_off = 0;
    wait_ends(1, "fs_c");
    check("fs_c_addr", last_ar_addr, 32'h0000_0800);
    check("fs_c_wr_count", wr_cnt, 64);
    do_burst(0, 0, 64, "fs_d", 1'b1);
    check("fs_d_addr", last_ar_addr, BASE);
    // frame_sync while idle takes effect on the very next burst.
    step();
    pulse_sync();
    m_off = 0;
    do_burst(1, 0, 8, "fs_idle", 1'b1);
    check("fs_idle_addr", last_ar_addr, BASE);

    // Randomized bursts against the model.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_sync();
        m_off = 0;
      end
      do_burst(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
               int'($urandom_range(1, 80)), "rand", 1'b1);
    end

    // Whole-frame walk with single-beat bursts (early rlast), then wrap.
    apply_reset();
    for (int i = 0; i < 3072; i++) do_burst(0, 0, 1, "wrap", 1'b0);
    check("wrap_last_addr", last_ar_addr, 32'h002F_FC00);
    do_burst(0, 0, 1, "wrap_next", 1'b1);
    check("wrap_next_addr", last_ar_addr, BASE);

    // Error response on beat 10, reset during beat 30.
    cfg_ar_delay = 0;
    cfg_gap      = 0;
    cfg_nbeats   = 64;
    cfg_err_beat = 10;
    cur_beat     = -1;
    push_addr();
    pulse_start();
    n = 0;
    while (cur_beat < 30 && n < 500) begin
      step();
      n++;
    end
    check("err_sticky", {127'd0, rd_err}, 128'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) step();
    cfg_err_beat = -1;
    exp_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    ar_active = 0;
    m_off     = 0;
    rst_n     = 1'b1;
    step();
    step();
    check_reset_outputs("post_mid_reset");
    do_burst(0, 0, 64, "post_reset", 1'b1);
    check("post_reset_addr", last_ar_addr, BASE);
    check("post_reset_rd_err", {127'd0, rd_err}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule
